// File: rtl/tv_checker.sv
// tv_checker: response checker for the 3-input gate tester.
// Each clock it samples the applied vector {in2,in1,in0} and the DUT response,
// and compares the response against the truth table of the gate latched at
// the start of the run. It also accumulates a saturating error count and
// per-vector coverage, and raises done/pass once enough full sweeps are seen.
//
// Parameters:
//   ERR_W   width of the saturating error counter
//   SWEEPS  full sweeps (samples of vector 7) required before done
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst        asynchronous reset, active-low
//   en         run enable (1 = check, 0 = stop/idle)
//   gate_sel   gate under test, latched on IDLE->RUN
//   in0..in2   applied vector bits
//   dut_out    DUT response to {in2,in1,in0}
//   expected   expected value of the last sampled vector
//   mismatch   1 = last sample failed
//   err_cnt    failing samples this run, saturating
//   vec_cov    bit i set once vector i has been sampled in RUN
//   done       1 in DONE state
//   pass       1 in DONE with no errors
//
// Optional feature (macro TVC_FIRST_FAIL_EN):
//   fail_valid, fail_vec, fail_obs capture the first failing sample of a run.

module tv_checker #(
   parameter int unsigned ERR_W  = 8,
   parameter int unsigned SWEEPS = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       gate_sel,
   input  logic             in0,
   input  logic             in1,
   input  logic             in2,
   input  logic             dut_out,
   output logic             expected,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_cnt,
   output logic [7:0]       vec_cov,
   output logic             done,
   output logic             pass
`ifdef TVC_FIRST_FAIL_EN
   ,
   output logic             fail_valid,
   output logic [2:0]       fail_vec,
   output logic             fail_obs
`endif
);

   localparam int unsigned SW_W = (SWEEPS < 1) ? 1 : $clog2(SWEEPS + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Registered state
   state_t           r_state;
   logic [2:0]       r_gate_q;
   logic             r_expected;
   logic             r_mismatch;
   logic [ERR_W-1:0] r_err_cnt;
   logic [7:0]       r_vec_cov;
   logic [SW_W-1:0]  r_sweep_cnt;
   logic             r_done;
   logic             r_pass;

   // Next-state values
   state_t           w_state_nxt;
   logic [2:0]       w_gate_nxt;
   logic             w_expected_nxt;
   logic             w_mismatch_nxt;
   logic [ERR_W-1:0] w_err_nxt;
   logic [7:0]       w_cov_nxt;
   logic [SW_W-1:0]  w_sweep_nxt;
   logic             w_done_nxt;
   logic             w_pass_nxt;

   logic [2:0]       w_idx;
   logic             w_exp;
   logic             w_miss;

`ifdef TVC_FIRST_FAIL_EN
   logic             r_fail_valid;
   logic [2:0]       r_fail_vec;
   logic             r_fail_obs;
   logic             w_fail_valid_nxt;
   logic [2:0]       w_fail_vec_nxt;
   logic             w_fail_obs_nxt;
`endif

   // Reference gate model; the reserved encoding behaves as AND
   function automatic logic f_gate(input logic [2:0] sel, input logic [2:0] v);
      logic a, b, c;
      a = v[0];
      b = v[1];
      c = v[2];
      case (sel)
         3'd0:    f_gate = a & b & c;
         3'd1:    f_gate = a | b | c;
         3'd2:    f_gate = ~(a & b & c);
         3'd3:    f_gate = ~(a | b | c);
         3'd4:    f_gate = a ^ b ^ c;
         3'd5:    f_gate = ~(a ^ b ^ c);
         3'd6:    f_gate = (a & b) | (a & c) | (b & c);
         default: f_gate = a & b & c;
      endcase
   endfunction

   assign w_idx  = {in2, in1, in0};
   assign w_exp  = f_gate(r_gate_q, w_idx);
   assign w_miss = (dut_out != w_exp);

   // State register and all result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_gate_q    <= 3'd0;
         r_expected  <= 1'b0;
         r_mismatch  <= 1'b0;
         r_err_cnt   <= '0;
         r_vec_cov   <= 8'h00;
         r_sweep_cnt <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_gate_q    <= w_gate_nxt;
         r_expected  <= w_expected_nxt;
         r_mismatch  <= w_mismatch_nxt;
         r_err_cnt   <= w_err_nxt;
         r_vec_cov   <= w_cov_nxt;
         r_sweep_cnt <= w_sweep_nxt;
         r_done      <= w_done_nxt;
         r_pass      <= w_pass_nxt;
      end
   end

`ifdef TVC_FIRST_FAIL_EN
   // First-failure capture registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fail_valid <= 1'b0;
         r_fail_vec   <= 3'd0;
         r_fail_obs   <= 1'b0;
      end else begin
         r_fail_valid <= w_fail_valid_nxt;
         r_fail_vec   <= w_fail_vec_nxt;
         r_fail_obs   <= w_fail_obs_nxt;
      end
   end
`endif

   // Next-state and result logic
   always_comb begin
      w_state_nxt    = r_state;
      w_gate_nxt     = r_gate_q;
      w_expected_nxt = r_expected;
      w_mismatch_nxt = r_mismatch;
      w_err_nxt      = r_err_cnt;
      w_cov_nxt      = r_vec_cov;
      w_sweep_nxt    = r_sweep_cnt;
      w_done_nxt     = r_done;
      w_pass_nxt     = r_pass;
`ifdef TVC_FIRST_FAIL_EN
      w_fail_valid_nxt = r_fail_valid;
      w_fail_vec_nxt   = r_fail_vec;
      w_fail_obs_nxt   = r_fail_obs;
`endif

      case (r_state)
         S_IDLE: begin
            // Start of a run clears results; no sample on this edge
            if (en) begin
               w_state_nxt    = S_RUN;
               w_gate_nxt     = gate_sel;
               w_expected_nxt = 1'b0;
               w_mismatch_nxt = 1'b0;
               w_err_nxt      = '0;
               w_cov_nxt      = 8'h00;
               w_sweep_nxt    = '0;
               w_done_nxt     = 1'b0;
               w_pass_nxt     = 1'b0;
`ifdef TVC_FIRST_FAIL_EN
               w_fail_valid_nxt = 1'b0;
               w_fail_vec_nxt   = 3'd0;
               w_fail_obs_nxt   = 1'b0;
`endif
            end
         end

         S_RUN: begin
            if (!en) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_expected_nxt = w_exp;
               w_mismatch_nxt = w_miss;
               if (w_miss && (r_err_cnt != {ERR_W{1'b1}})) begin
                  w_err_nxt = r_err_cnt + ERR_W'(1);
               end
               w_cov_nxt = r_vec_cov | 8'(8'd1 << w_idx);
               if ((w_idx == 3'd7) && (r_sweep_cnt != SW_W'(SWEEPS))) begin
                  w_sweep_nxt = r_sweep_cnt + SW_W'(1);
               end
`ifdef TVC_FIRST_FAIL_EN
               if (w_miss && !r_fail_valid) begin
                  w_fail_valid_nxt = 1'b1;
                  w_fail_vec_nxt   = w_idx;
                  w_fail_obs_nxt   = dut_out;
               end
`endif
               // Finish only once both sweep target and full coverage hold
               if ((w_sweep_nxt == SW_W'(SWEEPS)) && (w_cov_nxt == 8'hFF)) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_pass_nxt  = (w_err_nxt == '0);
               end
            end
         end

         S_DONE: begin
            // Leaving DONE drops done/pass; counters stay for inspection
            if (!en) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b0;
               w_pass_nxt  = 1'b0;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b0;
            w_pass_nxt  = 1'b0;
         end
      endcase
   end

   assign expected = r_expected;
   assign mismatch = r_mismatch;
   assign err_cnt  = r_err_cnt;
   assign vec_cov  = r_vec_cov;
   assign done     = r_done;
   assign pass     = r_pass;
`ifdef TVC_FIRST_FAIL_EN
   assign fail_valid = r_fail_valid;
   assign fail_vec   = r_fail_vec;
   assign fail_obs   = r_fail_obs;
`endif

endmodule
